bitwise_pipe_unit: RTL and testbench

//  Parametrised, pipelined bitwise logic unit: accepts operand pairs plus an opcode over a

---
 rtl/bitwise_pkg.sv | 36 +++
 rtl/bitwise_pipe_stage.sv | 38 +++
 rtl/bitwise_pipe_unit.sv | 103 ++++++++++
 tb/tb_bitwise_pipe_unit.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitwise_pkg.sv
// Purpose: shared opcode encodings and the per-bit evaluation function for the bitwise unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bitwise_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
  localparam logic [OP_W-1:0] OP_NOTA = 3'd6;
  localparam logic [OP_W-1:0] OP_PASS = 3'd7;

  // Single-bit evaluation; callers apply it across every bit position, so the
  // function stays width-independent. Operand b is ignored for NOT A / PASS A.
  function automatic logic bitwise_eval(input logic [OP_W-1:0] op, input logic a, input logic b);
    logic r;
    r = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      OP_NOTA: r = ~a;
      OP_PASS: r = a;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bitwise_pipe_stage.sv
// Purpose: one valid/ready register slice carrying a flat payload (result, opcode, optional flags).
// Latency: 1 cycle from accept to o_vld.
// Backpressure: o_rdy = slot empty or downstream taking the beat; data held stable while stalled.
module bitwise_pipe_stage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_vld,
  input  logic [DW-1:0] i_dat,
  output logic          o_rdy,
  input  logic          i_rdy,
  output logic          o_vld,
  output logic [DW-1:0] o_dat
);

  logic          r_vld;
  logic [DW-1:0] r_dat;

  // An empty slot can always load, so bubbles collapse while downstream stalls.
  assign o_rdy = !r_vld || i_rdy;
  assign o_vld = r_vld;
  assign o_dat = r_dat;

  // Load a new beat (or become empty) whenever this slot is free to move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= 1'b0;
      r_dat <= '0;
    end else if (o_rdy) begin
      r_vld <= i_vld;
      if (i_vld) begin
        r_dat <= i_dat;
      end
    end
  end

endmodule

// File: rtl/bitwise_pipe_unit.sv
// Purpose: pipelined 8-function bitwise unit with in-order results and a completed-transfer counter.
// Latency: STAGES cycles from accept to out_valid when unstalled; 1 beat/cycle throughput.
// Backpressure: in_ready falls only when every stage is full and out_ready is low (BITWISE_FLAGS_EN adds result flags).
module bitwise_pipe_unit
  import bitwise_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [OP_W-1:0]  out_op,
  output logic [CNT_W-1:0] xfer_count
`ifdef BITWISE_FLAGS_EN
  ,
  output logic                       out_zero,
  output logic                       out_parity,
  output logic [$clog2(WIDTH+1)-1:0] out_ones
`endif
);

  localparam int ONES_W = $clog2(WIDTH + 1);
`ifdef BITWISE_FLAGS_EN
  localparam int FLAG_W = 2 + ONES_W;
`else
  localparam int FLAG_W = 0;
`endif
  localparam int PW = FLAG_W + OP_W + WIDTH;

  logic [WIDTH-1:0] w_y;
  logic             w_vld [0:STAGES];
  logic             w_rdy [0:STAGES];
  logic [PW-1:0]    w_dat [0:STAGES];
  logic [CNT_W-1:0] r_xfer_count;

  // Stage-0 evaluation: apply the selected function independently at every bit.
  always_comb begin
    w_y = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_y[i] = bitwise_eval(in_op, in_a[i], in_b[i]);
    end
  end

`ifdef BITWISE_FLAGS_EN
  logic [ONES_W-1:0] w_ones;

  // Population count of the fresh result; flags ride with the beat from here on.
  always_comb begin
    w_ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_ones = w_ones + ONES_W'(w_y[i]);
    end
  end

  assign w_dat[0] = {(w_y == '0), ^w_y, w_ones, in_op, w_y};
  assign {out_zero, out_parity, out_ones, out_op, out_y} = w_dat[STAGES];
`else
  assign w_dat[0] = {in_op, w_y};
  assign {out_op, out_y} = w_dat[STAGES];
`endif

  assign w_vld[0]      = in_valid;
  assign in_ready      = w_rdy[0];
  assign out_valid     = w_vld[STAGES];
  assign w_rdy[STAGES] = out_ready;

  // Chain of register slices; each slot's ready feeds the slot upstream of it.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    bitwise_pipe_stage #(
      .DW (PW)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .i_vld (w_vld[k]),
      .i_dat (w_dat[k]),
      .o_rdy (w_rdy[k]),
      .i_rdy (w_rdy[k+1]),
      .o_vld (w_vld[k+1]),
      .o_dat (w_dat[k+1])
    );
  end

  // Count completed output handshakes; wraps naturally at 2**CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xfer_count <= '0;
    end else if (out_valid && out_ready) begin
      r_xfer_count <= r_xfer_count + 1'b1;
    end
  end

  assign xfer_count = r_xfer_count;

endmodule

// File: tb/tb_bitwise_pipe_unit.sv
// Purpose: self-checking bench for bitwise_pipe_unit (WIDTH=8, STAGES=2, CNT_W=4).
// Latency: expects results STAGES cycles after accept when unstalled.
// Backpressure: drives random out_ready and holds input beats until accepted.
module tb_bitwise_pipe_unit;

  localparam int W  = 8;
  localparam int ST = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [2:0]    in_op = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_y;
  logic [2:0]    out_op;
  logic [CW-1:0] xfer_count;
`ifdef BITWISE_FLAGS_EN
  logic          out_zero;
  logic          out_parity;
  logic [3:0]    out_ones;
`endif

  always #5 clk = ~clk;

  bitwise_pipe_unit #(.WIDTH(W), .STAGES(ST), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_op     (out_op),
    .xfer_count (xfer_count)
`ifdef BITWISE_FLAGS_EN
    ,
    .out_zero   (out_zero),
    .out_parity (out_parity),
    .out_ones   (out_ones)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [7:0] y;
    logic [2:0] op;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [7:0] y;
    logic [2:0] op;
    int         lat;
    logic       z;
    logic       p;
    logic [3:0] ones;
  } obs_t;

  exp_t       exp_q[$];
  obs_t       log_q[$];
  logic [3:0] lut [8];
  int         cyc = 0;
  int         n_acc = 0;
  logic [3:0] m_count = '0;
  logic       last_fire_in = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_y = '0;
  logic [2:0] prev_op = '0;

  // Reference: each opcode is a 2-input truth table indexed by {a_bit, b_bit}.
  function automatic logic [7:0] ref_y(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [3:0] t;
    t = lut[op];
    for (int i = 0; i < 8; i++) r[i] = t[{a[i], b[i]}];
    return r;
  endfunction

  // One clock: called at a falling edge with inputs already applied.
  task automatic step();
    logic fi;
    logic fo;
    exp_t e;
    obs_t o;
    #1;
    fi = in_valid && in_ready;
    fo = out_valid && out_ready;
    check_eq("xfer_count", 32'(xfer_count), 32'(m_count));
    if (prev_stall) begin
      check_eq("hold_y", 32'(out_y), 32'(prev_y));
      check_eq("hold_op", 32'(out_op), 32'(prev_op));
    end
    if (exp_q.size() == 0) check_eq("spurious_out", 32'(out_valid), 32'd0);
    if (fo && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_eq("out_y", 32'(out_y), 32'(e.y));
      check_eq("out_op", 32'(out_op), 32'(e.op));
      o.y = out_y; o.op = out_op; o.lat = cyc - e.cyc;
      o.z = 1'b0; o.p = 1'b0; o.ones = '0;
`ifdef BITWISE_FLAGS_EN
      check_eq("out_zero", 32'(out_zero), 32'(e.y == 8'h00));
      check_eq("out_parity", 32'(out_parity), 32'($countones(e.y) % 2));
      check_eq("out_ones", 32'(out_ones), 32'($countones(e.y)));
      o.z = out_zero; o.p = out_parity; o.ones = out_ones;
`endif
      log_q.push_back(o);
      m_count = m_count + 4'd1;
    end
    if (fi) begin
      exp_q.push_back('{ref_y(in_op, in_a, in_b), in_op, cyc});
      n_acc++;
    end
    last_fire_in = fi;
    prev_stall   = out_valid && !out_ready;
    prev_y       = out_y;
    prev_op      = out_op;
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_count", 32'(xfer_count), 32'd0);
    check_eq("rst_out_y", 32'(out_y), 32'd0);
    check_eq("rst_out_op", 32'(out_op), 32'd0);
`ifdef BITWISE_FLAGS_EN
    check_eq("rst_flags", 32'({out_zero, out_parity, out_ones}), 32'd0);
`endif
    exp_q.delete();
    log_q.delete();
    m_count = '0;
    prev_stall = 1'b0;
    last_fire_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
  endtask

  // Present a beat and hold it until accepted (bounded).
  task automatic send_hold(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
    for (int i = 0; i < 30; i++) begin
      step();
      if (last_fire_in) break;
    end
    check_eq("send_accepted", 32'(last_fire_in), 32'd1);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 30 && (exp_q.size() != 0 || out_valid); i++) step();
    check_eq("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  logic [7:0] t1_exp [4];
  int         idx;
  int         start;
  int         guard;

  initial begin
    lut[0] = 4'b1000; lut[1] = 4'b1110; lut[2] = 4'b0110; lut[3] = 4'b0111;
    lut[4] = 4'b0001; lut[5] = 4'b1001; lut[6] = 4'b0011; lut[7] = 4'b1100;
    t1_exp[0] = 8'h24; t1_exp[1] = 8'hBD; t1_exp[2] = 8'h99; t1_exp[3] = 8'hDB;

    @(negedge clk);
    do_reset();

    // Test 1: four ops back-to-back, fixed operands, no stall
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_hold(8'hA5, 8'h3C, 3'(i));
    drain();
    check_eq("t1_count", 32'(log_q.size()), 32'd4);
    if (log_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check_eq("t1_y", 32'(log_q[i].y), 32'(t1_exp[i]));
        check_eq("t1_op", 32'(log_q[i].op), 32'(i));
        check_eq("t1_latency", 32'(log_q[i].lat), 32'(ST));
      end
    end

    // Test 2: stall output, fill the pipe, then release
    do_reset();
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; in_a = 8'(idx * 17 + 3); in_b = 8'h5A; in_op = 3'(idx);
      step();
      if (last_fire_in) idx++;
    end
    check_eq("t2_accepted_full", 32'(idx), 32'd2);
    check_eq("t2_in_ready_full", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 30 && idx < 4; c++) begin
      in_valid = 1'b1; in_a = 8'(idx * 17 + 3); in_b = 8'h5A; in_op = 3'(idx);
      step();
      if (last_fire_in) idx++;
    end
    drain();
    check_eq("t2_count", 32'(log_q.size()), 32'd4);
    if (log_q.size() == 4) begin
      for (int i = 0; i < 4; i++) check_eq("t2_order", 32'(log_q[i].op), 32'(i));
    end

    // Test 3: unary ops ignore operand b
    log_q.delete();
    send_hold(8'h0F, 8'hFF, 3'd6);
    send_hold(8'h0F, 8'hFF, 3'd7);
    drain();
    check_eq("t3_count", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      check_eq("t3_nota", 32'(log_q[0].y), 32'h F0);
      check_eq("t3_pass", 32'(log_q[1].y), 32'h 0F);
    end

    // Test 4: counter wrap after 17 transfers
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) send_hold(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
    drain();
    check_eq("t4_wrap_count", 32'(xfer_count), 32'd1);

    // Test 5: reset with beats in flight
    do_reset();
    out_ready = 1'b0;
    send_hold(8'h12, 8'h34, 3'd1);
    send_hold(8'h56, 8'h78, 3'd2);
    in_valid = 1'b0;
    step();
    check_eq("t5_inflight_valid", 32'(out_valid), 32'd1);
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();

`ifdef BITWISE_FLAGS_EN
    // Test 6: result flags on known values
    log_q.delete();
    send_hold(8'h00, 8'h00, 3'd0);
    send_hold(8'hA5, 8'h3C, 3'd2);
    send_hold(8'h01, 8'h00, 3'd7);
    drain();
    check_eq("t6_count", 32'(log_q.size()), 32'd3);
    if (log_q.size() == 3) begin
      check_eq("t6_zero0", 32'(log_q[0].z), 32'd1);
      check_eq("t6_par0", 32'(log_q[0].p), 32'd0);
      check_eq("t6_ones0", 32'(log_q[0].ones), 32'd0);
      check_eq("t6_zero1", 32'(log_q[1].z), 32'd0);
      check_eq("t6_par1", 32'(log_q[1].p), 32'd0);
      check_eq("t6_ones1", 32'(log_q[1].ones), 32'd4);
      check_eq("t6_par2", 32'(log_q[2].p), 32'd1);
      check_eq("t6_ones2", 32'(log_q[2].ones), 32'd1);
    end
`endif

    // Random run: 1000 beats with random valid and random backpressure
    do_reset();
    start = n_acc;
    guard = 0;
    while (n_acc - start < 1000 && guard < 20000) begin
      if (!in_valid || last_fire_in) begin
        if (n_acc - start < 1000) begin
          in_valid = ($urandom_range(0, 3) != 0);
          in_a  = 8'($urandom);
          in_b  = 8'($urandom);
          in_op = 3'($urandom_range(0, 7));
        end
      end
      out_ready = ($urandom_range(0, 2) != 0);
      step();
      guard++;
    end
    check_eq("rand_accepted", 32'(n_acc - start), 32'd1000);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
